// File: rtl/sli_cam_sync_if.sv
// Projector/camera SLI handshake bundle: the projector (master) drives trigger, arm and timing,
// and the camera (slave) answers with rdy and status.
interface sli_cam_sync_if #(
  parameter int CNT_W = 24
);
  logic             arm;
  logic             trig;
  logic             f_frm;
  logic [CNT_W-1:0] exp_cycles;
  logic [CNT_W-1:0] ro_cycles;
  logic             rdy;
  logic             busy;
  logic [4:0]       frame_idx;
  logic             seq_done;
  logic             overrun;

  modport master (
    output arm, trig, f_frm, exp_cycles, ro_cycles,
    input  rdy, busy, frame_idx, seq_done, overrun
  );

  modport slave (
    input  arm, trig, f_frm, exp_cycles, ro_cycles,
    output rdy, busy, frame_idx, seq_done, overrun
  );
endinterface

// File: rtl/sli_cam_sync.sv
// Camera model for the SLI handshake: synced trig rise -> EXPOSE -> READOUT -> ACK (rdy for RDY_W clk).
// Trig-to-EXPOSE latency SYNC_STAGES+1 clk; triggers while busy are dropped. SLI_CAM_PRIME_EN adds a PRIME rdy on arm rise.
module sli_cam_sync #(
  parameter int CNT_W       = 24,
  parameter int RDY_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int SEQ_LEN     = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  sli_cam_sync_if.slave cam
);
  localparam int              RC_W     = (RDY_W > 1) ? $clog2(RDY_W) : 1;
  localparam logic [RC_W-1:0] RDY_LOAD = RC_W'(RDY_W - 1);
  localparam logic [4:0]      IDX_LAST = 5'(SEQ_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    EXPOSE,
    READOUT,
    ACK
`ifdef SLI_CAM_PRIME_EN
    , PRIME
`endif
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] trig_sync;
  logic [SYNC_STAGES-1:0] ffrm_sync;
  logic                   trig_d;
  logic [CNT_W-1:0]       cnt;
  logic [RC_W-1:0]        rdy_cnt;
  logic                   rdy_r;
  logic                   busy_r;
  logic [4:0]             idx_r;
  logic                   seq_done_r;
  logic                   overrun_r;
  logic                   trig_rise;
  logic                   f_frm_s;
  logic [4:0]             idx_next;
`ifdef SLI_CAM_PRIME_EN
  logic                   arm_d;
  logic                   arm_rise;

  assign arm_rise = cam.arm & ~arm_d;
`endif

  assign trig_rise = trig_sync[SYNC_STAGES-1] & ~trig_d;
  assign f_frm_s   = ffrm_sync[SYNC_STAGES-1];
  assign idx_next  = (idx_r == IDX_LAST) ? 5'd0 : idx_r + 5'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      trig_sync  <= '0;
      ffrm_sync  <= '0;
      trig_d     <= 1'b0;
      cnt        <= '0;
      rdy_cnt    <= '0;
      rdy_r      <= 1'b0;
      busy_r     <= 1'b0;
      idx_r      <= '0;
      seq_done_r <= 1'b0;
      overrun_r  <= 1'b0;
`ifdef SLI_CAM_PRIME_EN
      arm_d      <= 1'b0;
`endif
    end else begin
      trig_sync  <= {trig_sync[SYNC_STAGES-2:0], cam.trig};
      ffrm_sync  <= {ffrm_sync[SYNC_STAGES-2:0], cam.f_frm};
      trig_d     <= trig_sync[SYNC_STAGES-1];
      seq_done_r <= 1'b0;
`ifdef SLI_CAM_PRIME_EN
      arm_d      <= cam.arm;
`endif
      if (!cam.arm) begin
        // Disarm aborts any frame; frame_idx is kept so a re-arm resumes the sequence.
        state     <= IDLE;
        busy_r    <= 1'b0;
        rdy_r     <= 1'b0;
        overrun_r <= 1'b0;
        cnt       <= '0;
        rdy_cnt   <= '0;
      end else begin
        if (trig_rise && state != IDLE) overrun_r <= 1'b1;
        case (state)
          IDLE: begin
            if (trig_rise) begin
              state  <= EXPOSE;
              busy_r <= 1'b1;
              cnt    <= (cam.exp_cycles == '0) ? '0 : cam.exp_cycles - 1'b1;
              if (f_frm_s) idx_r <= IDX_LAST;
            end
`ifdef SLI_CAM_PRIME_EN
            else if (arm_rise) begin
              state   <= PRIME;
              busy_r  <= 1'b1;
              rdy_r   <= 1'b1;
              rdy_cnt <= RDY_LOAD;
            end
`endif
          end
          EXPOSE: begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else if (cam.ro_cycles != '0) begin
              state <= READOUT;
              cnt   <= cam.ro_cycles - 1'b1;
            end else begin
              state      <= ACK;
              rdy_r      <= 1'b1;
              rdy_cnt    <= RDY_LOAD;
              idx_r      <= idx_next;
              seq_done_r <= (idx_next == IDX_LAST);
            end
          end
          READOUT: begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else begin
              // seq_done marks completion of the last frame, not the f_frm realign wrap.
              state      <= ACK;
              rdy_r      <= 1'b1;
              rdy_cnt    <= RDY_LOAD;
              idx_r      <= idx_next;
              seq_done_r <= (idx_next == IDX_LAST);
            end
          end
`ifdef SLI_CAM_PRIME_EN
          ACK, PRIME: begin
`else
          ACK: begin
`endif
            if (rdy_cnt != '0) begin
              rdy_cnt <= rdy_cnt - 1'b1;
            end else begin
              state  <= IDLE;
              busy_r <= 1'b0;
              rdy_r  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign cam.rdy       = rdy_r;
  assign cam.busy      = busy_r;
  assign cam.frame_idx = idx_r;
  assign cam.seq_done  = seq_done_r;
  assign cam.overrun   = overrun_r;
endmodule

// File: tb/tb_sli_cam_sync.sv
// Scoreboarded bench for sli_cam_sync: a frame-level timing model predicts each rdy pulse,
// and a negedge monitor pops and compares on every rdy rise.
`timescale 1ns/1ps
module tb_sli_cam_sync;
  localparam int CNT_W       = 24;
  localparam int RDY_W       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int SEQ_LEN     = 32;
`ifdef SLI_CAM_PRIME_EN
  localparam int PRIME_PULSES = 1;
`else
  localparam int PRIME_PULSES = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sli_cam_sync_if #(.CNT_W(CNT_W)) cif();

  sli_cam_sync #(
    .CNT_W(CNT_W), .RDY_W(RDY_W), .SYNC_STAGES(SYNC_STAGES), .SEQ_LEN(SEQ_LEN)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .cam  (cif.slave)
  );

  typedef struct {
    int start;
    int idx;
    int sd;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  // Frame-level model: busy_until is the first cycle the camera is idle again.
  int idx_m = 0;
  int busy_until = 0;
  int sd_exp = 0;
  bit ov_m = 1'b0;
  bit arm_m = 1'b0;

  bit rdy_q = 1'b0;
  int width = 0;
  int sd_seen = 0;
  int rdy_rises = 0;
  int r0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      rdy_q = 1'b0;
      width = 0;
    end else begin
      if (cif.rdy && !rdy_q) begin
        rdy_rises++;
        width = 1;
        if (sb.size() == 0) begin
          chk("rdy_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("rdy_start", cyc, e.start);
          chk("frame_idx", int'(cif.frame_idx), e.idx);
          chk("seq_done_at_ack", int'(cif.seq_done), e.sd);
        end
      end else if (cif.rdy) begin
        width++;
      end else if (rdy_q) begin
        chk("rdy_width", width, RDY_W);
      end
      if (cif.seq_done) sd_seen++;
      rdy_q = cif.rdy;
    end
  end

  // Raise trig (and f_frm) at the current negedge for 3 clk; optionally predict the outcome.
  task automatic trig_pulse(input bit ff, input bit use_model);
    int k, p, r, ex;
    k = cyc;
    cif.trig  = 1'b1;
    cif.f_frm = ff;
    if (use_model && arm_m) begin
      p = k + SYNC_STAGES + 1;
      if (p - 1 < busy_until) begin
        ov_m = 1'b1;
      end else begin
        ex = (cif.exp_cycles == '0) ? 1 : int'(cif.exp_cycles);
        r  = p + ex + int'(cif.ro_cycles);
        if (ff) idx_m = SEQ_LEN - 1;
        idx_m = (idx_m + 1) % SEQ_LEN;
        sb.push_back('{r, idx_m, (idx_m == SEQ_LEN - 1) ? 1 : 0});
        if (idx_m == SEQ_LEN - 1) sd_exp++;
        busy_until = r + RDY_W;
      end
    end
    repeat (3) @(negedge clk);
    cif.trig  = 1'b0;
    cif.f_frm = 1'b0;
  endtask

  task automatic wait_idle();
    while (cyc < busy_until + 2) @(negedge clk);
  endtask

  task automatic arm_up();
    cif.arm = 1'b1;
    arm_m   = 1'b1;
`ifdef SLI_CAM_PRIME_EN
    sb.push_back('{cyc + 1, idx_m, 0});
    busy_until = cyc + 1 + RDY_W;
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    cif.arm = 1'b0; cif.trig = 1'b0; cif.f_frm = 1'b0;
    cif.exp_cycles = '0; cif.ro_cycles = '0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cif.trig  = ~cif.trig;
      cif.f_frm = cif.trig;
      chk("reset_outputs", int'({cif.rdy, cif.busy, cif.frame_idx, cif.overrun}), 0);
    end
    @(negedge clk);
    cif.trig = 1'b0; cif.f_frm = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    arm_up();
    @(negedge clk);
    wait_idle();

    // Nominal frame with busy latency check.
    cif.exp_cycles = 100; cif.ro_cycles = 50;
    fork
      trig_pulse(1'b0, 1'b1);
      begin
        repeat (2) @(negedge clk);
        chk("busy_before_latency", int'(cif.busy), 0);
        @(negedge clk);
        chk("busy_after_latency", int'(cif.busy), 1);
      end
    join
    wait_idle();

    // 33 frames, first one realigned by f_frm.
    cif.exp_cycles = 5; cif.ro_cycles = 3;
    for (int i = 0; i < 33; i++) begin
      trig_pulse(i == 0, 1'b1);
      wait_idle();
    end
    chk("seq_done_count", sd_seen, sd_exp);

    // Second trigger 200 clk into a 1000 clk exposure.
    cif.exp_cycles = 1000; cif.ro_cycles = 10;
    chk("overrun_clear", int'(cif.overrun), 0);
    trig_pulse(1'b0, 1'b1);
    repeat (197) @(negedge clk);
    trig_pulse(1'b0, 1'b1);
    repeat (10) @(negedge clk);
    chk("overrun_set", int'(cif.overrun), int'(ov_m));
    wait_idle();
    chk("overrun_sticky", int'(cif.overrun), int'(ov_m));

    // Zero exposure and zero readout.
    cif.exp_cycles = 0; cif.ro_cycles = 0;
    trig_pulse(1'b0, 1'b1);
    wait_idle();

    // Disarm during the single EXPOSE cycle.
    fork
      trig_pulse(1'b0, 1'b0);
      begin
        repeat (3) @(negedge clk);
        chk("expose_busy", int'(cif.busy), 1);
        cif.arm = 1'b0; arm_m = 1'b0; ov_m = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(cif.busy), 0);
        chk("abort_overrun", int'(cif.overrun), int'(ov_m));
        chk("abort_rdy", int'(cif.rdy), 0);
      end
    join
    repeat (10) @(negedge clk);
    trig_pulse(1'b0, 1'b1);
    repeat (12) @(negedge clk);
    chk("disarmed_busy", int'(cif.busy), 0);
    chk("disarmed_overrun", int'(cif.overrun), 0);
    chk("frame_idx_held", int'(cif.frame_idx), idx_m);

    r0 = rdy_rises;
    arm_up();
    repeat (20) @(negedge clk);
    chk("arm_rise_rdy_pulses", rdy_rises - r0, PRIME_PULSES);
    wait_idle();

    // Random exposure/readout lengths and trigger spacing; some triggers overrun.
    for (int n = 0; n < 150; n++) begin
      if (cyc >= busy_until) begin
        cif.exp_cycles = CNT_W'($urandom_range(0, 40));
        cif.ro_cycles  = CNT_W'($urandom_range(0, 30));
      end
      trig_pulse($urandom_range(0, 7) == 0, 1'b1);
      repeat ($urandom_range(3, 60)) @(negedge clk);
    end
    wait_idle();
    chk("rand_busy", int'(cif.busy), 0);
    chk("rand_overrun", int'(cif.overrun), int'(ov_m));
    chk("sb_drained", sb.size(), 0);
    chk("seq_done_total", sd_seen, sd_exp);

    // Asynchronous reset in the middle of an exposure.
    cif.exp_cycles = 200; cif.ro_cycles = 20;
    trig_pulse(1'b0, 1'b1);
    repeat (20) @(negedge clk);
    chk("busy_before_reset", int'(cif.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset", int'({cif.rdy, cif.busy, cif.frame_idx, cif.overrun, cif.seq_done}), 0);
    sb.delete();
    cif.arm = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
